// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit register bank.
// Optional macro ARB_HOLD_EN: lets a granted requester write up to HOLD_MAX times before priority rotates.
module dff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   din,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        Q,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    valid
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [IW-1:0]     sel, sel_n;
    logic [IW-1:0]     ptr, ptr_n;
    logic [NREQ-1:0]   gnt_n, ack_n;
    logic [WIDTH-1:0]  q_n;
    logic [IW-1:0]     owner_n;
    logic              valid_n;

`ifdef ARB_HOLD_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0]     cnt, cnt_n;
`endif

    logic [WIDTH-1:0]  words [NREQ];
    logic [IW-1:0]     rot;
    logic [IW-1:0]     base;
    logic [IW:0]       scan;
    logic              found;
    logic [IW-1:0]     pick;

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = din[i*WIDTH +: WIDTH];
    end

    // After a write, priority moves to the requester just past the one served.
    assign rot  = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
    assign base = (state == WRITE) ? rot : ptr;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, base} + (IW+1)'(i);
            if (scan >= (IW+1)'(NREQ)) begin
                scan = scan - (IW+1)'(NREQ);
            end
            if (!found && req[scan[IW-1:0]]) begin
                found = 1'b1;
                pick  = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        gnt_n   = '0;
        ack_n   = '0;
        q_n     = Q;
        owner_n = owner;
        valid_n = valid;
`ifdef ARB_HOLD_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n       = pick;
                    gnt_n[pick] = 1'b1;
                    state_n     = GRANT;
`ifdef ARB_HOLD_EN
                    cnt_n       = '0;
`endif
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    q_n        = words[sel];
                    owner_n    = sel;
                    valid_n    = 1'b1;
                    ack_n[sel] = 1'b1;
                    state_n    = WRITE;
`ifdef ARB_HOLD_EN
                    cnt_n      = cnt + 1'b1;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
`ifdef ARB_HOLD_EN
                if (req[sel] && (cnt < CW'(HOLD_MAX))) begin
                    gnt_n[sel] = 1'b1;
                    state_n    = GRANT;
                end else
`endif
                begin
                    ptr_n = rot;
                    if (found) begin
                        sel_n       = pick;
                        gnt_n[pick] = 1'b1;
                        state_n     = GRANT;
`ifdef ARB_HOLD_EN
                        cnt_n       = '0;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: all state, including the shared data register, uses non-blocking assignments and a synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            ack   <= '0;
            Q     <= '0;
            owner <= '0;
            valid <= 1'b0;
`ifdef ARB_HOLD_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            Q     <= q_n;
            owner <= owner_n;
            valid <= valid_n;
`ifdef ARB_HOLD_EN
            cnt   <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: reset, single write, rotation, withdrawal, mid-grant reset, back-to-back sharing.
// Build with ARB_HOLD_EN defined to expect the hold-grant sequence in the last step.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .ack   (ack),
        .Q     (q),
        .owner (owner),
        .valid (valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] words [4];
        int         seq [$];

        // Reset held with every requester asking.
        rst = 1'b0;
        req = 4'b1111;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_gnt",   gnt,   0);
            check("rst_ack",   ack,   0);
            check("rst_q",     q,     0);
            check("rst_valid", valid, 0);
            check("rst_owner", owner, 0);
        end
        rst = 1'b1;
        tick();
        check("rel_gnt", gnt, 4'b0001);
        check("rel_ack", ack, 0);

        // Requester 0 withdraws during its grant: no write.
        req = 4'b0100;
        tick();
        check("wd_gnt",   gnt,   0);
        check("wd_ack",   ack,   0);
        check("wd_valid", valid, 0);

        // Single requester 2 write.
        din[23:16] = 8'hA5;
        tick();
        check("t2_gnt", gnt, 4'b0100);
        check("t2_ack_early", ack, 0);
        check("t2_q_early", q, 0);
        tick();
        check("t2_q",     q,     8'hA5);
        check("t2_ack",   ack,   4'b0100);
        check("t2_owner", owner, 2);
        check("t2_valid", valid, 1);
        check("t2_gnt_off", gnt, 0);
        req = 4'b0000;
        tick();
        check("t2_ack_pulse", ack, 0);
        check("t2_idle_gnt", gnt, 0);
        check("t2_hold1", q, 8'hA5);
        tick();
        check("t2_hold2", q, 8'hA5);

        // Requester 3 write parks the pointer back at 0.
        req = 4'b1000;
        din[31:24] = 8'h44;
        tick();
        check("p3_gnt", gnt, 4'b1000);
        tick();
        check("p3_ack",   ack,   4'b1000);
        check("p3_q",     q,     8'h44);
        check("p3_owner", owner, 3);
        req = 4'b0000;
        tick();
        check("p3_idle", gnt, 0);

        // All four requesting: round-robin 0,1,2,3,0, one write per two cycles.
        req = 4'b1111;
        din[23:16] = 8'h33;
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_gnt", gnt, 32'd1 << (k % 4));
            check("rr_gnt_ack", ack, 0);
            tick();
            check("rr_ack",   ack,   32'd1 << (k % 4));
            check("rr_q",     q,     words[k % 4]);
            check("rr_owner", owner, k % 4);
            check("rr_ack_gnt", gnt, 0);
        end
        req = 4'b0000;
        tick();
        check("rr_idle", gnt, 0);

        // Requester 1 withdraws; pointer stays at 1 so it wins the next contest.
        req = 4'b0010;
        tick();
        check("t4_gnt", gnt, 4'b0010);
        req = 4'b0000;
        tick();
        check("t4_wd_gnt",   gnt,   0);
        check("t4_wd_ack",   ack,   0);
        check("t4_wd_q",     q,     8'h11);
        check("t4_wd_owner", owner, 0);
        req = 4'b0011;
        tick();
        check("t4_regrant", gnt, 4'b0010);
        tick();
        check("t4_ack", ack, 4'b0010);
        check("t4_q",   q,   8'h22);
        req = 4'b0000;
        tick();

        // Reset lands in the GRANT cycle of requester 3.
        rst = 1'b0;
        tick();
        check("t5_pre_q",     q,     0);
        check("t5_pre_valid", valid, 0);
        rst = 1'b1;
        req = 4'b1000;
        din[31:24] = 8'hFF;
        tick();
        check("t5_gnt", gnt, 4'b1000);
        rst = 1'b0;
        tick();
        check("t5_gnt_rst", gnt,   0);
        check("t5_ack_rst", ack,   0);
        check("t5_q_rst",   q,     0);
        check("t5_owner",   owner, 0);
        check("t5_valid",   valid, 0);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        check("t5_no_late_ack", ack, 0);
        check("t5_no_late_q",   q,   0);

        // Requesters 0 and 1 both held high.
        req = 4'b0011;
        din[7:0]  = 8'h5A;
        din[15:8] = 8'hC3;
`ifdef ARB_HOLD_EN
        seq = '{0, 0, 0, 0, 1};
`else
        seq = '{0, 1, 0, 1};
`endif
        foreach (seq[k]) begin
            tick();
            check("t6_gnt", gnt, 32'd1 << seq[k]);
            tick();
            check("t6_ack", ack, 32'd1 << seq[k]);
            check("t6_q",   q,   (seq[k] == 0) ? 8'h5A : 8'hC3);
        end
        req = 4'b0000;
        tick();
        tick();
        check("t6_idle", gnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
